seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Scans a 16-bit hex value across a 4-digit common-anode 7-segment display, one digit at a time.
- Sits between the datapath that produces a display value and the board pins (AN, a_to_g, dp). It feeds a per-digit hex-to-segment decoder internally.
- Adds:
  - frame-synchronous value update, so the display never tears mid-scan;
  - per-digit enable mask;
  - decimal points;
  - leading-zero blanking.

Parameters:
- PRESCALE, 100000, clocks per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
- CNT_W, 20, prescaler counter width; must satisfy 2^CNT_W >= PRESCALE.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- x  in  16  display value; digit 0 = x[3:0] (rightmost), digit 3 = x[15:12].
- load  in  1  single-cycle strobe; captures x, dp_in, en_in into the pending register.
- dp_in  in  4  decimal point per digit, 1 = lit.
- en_in  in  4  digit enable per digit, 1 = shown.
- lz_en  in  1  leading-zero blanking enable (live, not latched).
- AN  out  4  anode selects, active-low, registered.
- a_to_g  out  7  segments a..g, a = bit 6, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- frame  out  1  one-cycle pulse when the active register is (re)loaded at a frame start.
- pending  out  1  high while a loaded value waits for a frame boundary.

Behaviour:
- Reset (async, clr=1):
  - prescaler=0, idx=0;
  - active and pending registers=0, pending=0, frame=0;
  - AN=4'b1111, a_to_g=7'b1111111, dp=1 (all dark).
- Prescaler:
  - counts 0..PRESCALE-1, then wraps to 0.
  - tick is asserted in the cycle where count==PRESCALE-1.
- Digit index: on tick, idx advances 0->1->2->3->0. No other state changes idx.
- Frame boundary: a tick while idx==3 (idx wraps to 0).
  - If pending=1 at that edge: active <= pending register, pending <= 0, frame <= 1 for exactly one cycle.
  - Otherwise frame stays 0.
- load:
  - On any edge with load=1: pending register <= {x, dp_in, en_in}, pending <= 1.
  - A later load before the boundary overwrites the earlier one; only the last load is displayed.
  - Simultaneous load and frame boundary: active takes the OLD pending contents, the pending register takes the new x, and pending stays 1.
  - load with pending=0 at a boundary edge does not reach active in that frame.
- Output register, updated every clock from the current idx and active (1-cycle latency after idx changes):
  - AN = one-cold at idx (idx0 -> 1110, idx1 -> 1101, idx2 -> 1011, idx3 -> 0111) if the digit is shown, else 1111.
  - A digit is shown iff active.en[idx]=1 AND NOT blank[idx].
  - blank[i] = lz_en AND i!=0 AND every nibble from i up to 3 is zero. Digit 0 is never zero-blanked.
  - a_to_g = active-low decode of the nibble:
    - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
    - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
    - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
    - C = 0110001, d = 1000010, E = 0110000, F = 0111000
    - a_to_g = 1111111 when the digit is not shown.
  - dp = ~active.dp[idx] when shown, else 1.
- Out of reset: the first clock edge with clr=0 drives AN=1111 (active.en=0).
- Reset mid-frame: all state clears immediately, outputs go dark, and scanning restarts at idx 0 with count 0.

Decomposition:
- Shared package holds:
  - SEG_BLANK = 7'b1111111;
  - AN_OFF = 4'b1111;
  - the digit-record typedef {nibbles[15:0], dp[3:0], en[3:0]}.
- One natural sub-module: seg_decode, a combinational 4-bit nibble to 7-bit active-low segment table (values above).
- The scan FSM, prescaler, latching and blanking stay in seg7_scan.

Test Plan (PRESCALE=4):
- Reset held then released, no load -> AN=1111, a_to_g=1111111, dp=1, frame=0 for 3 full frames.
- load x=16'h12AF, en=1111, dp=0100 -> pending=1 until the boundary; one frame pulse; then per slot:
  - AN=1110 seg=0111000;
  - AN=1101 seg=0001000;
  - AN=1011 seg=0010010 dp=0;
  - AN=0111 seg=1001111.
- lz_en=1, x=16'h0050, en=1111 -> digits 3 and 2 dark (AN=1111 in their slots); digit 1 shows 5 (0100100); digit 0 shows 0 (0000001).
- x=16'h0000, lz_en=1 -> only digit 0 lit with 0000001; en_in=1110 with any x -> digit 0 slot AN=1111.
- load pulses in the same cycle as a boundary, then a second load -> boundary shows the old pending value; the next boundary shows the newest; pending deasserts only after it.
- Assert clr during idx=2 mid-slot -> outputs dark within the same cycle (async); after release, idx restarts at 0 and the first tick occurs 4 clocks later.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
package seg7_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef struct packed {
        logic [15:0] nibbles;
        logic [3:0]  dp;
        logic [3:0]  en;
    } digit_rec_t;

    // One-cold anode select for a digit index (active-low anodes).
    function automatic logic [3:0] an_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low 7-segment pattern; bit 6 = segment a.
module seg_decode (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (nib_i)
            4'h0: seg_o = 7'b0000001;
            4'h1: seg_o = 7'b1001111;
            4'h2: seg_o = 7'b0010010;
            4'h3: seg_o = 7'b0000110;
            4'h4: seg_o = 7'b1001100;
            4'h5: seg_o = 7'b0100100;
            4'h6: seg_o = 7'b0100000;
            4'h7: seg_o = 7'b0001111;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0000100;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b1100000;
            4'hC: seg_o = 7'b0110001;
            4'hD: seg_o = 7'b1000010;
            4'hE: seg_o = 7'b0110000;
            4'hF: seg_o = 7'b0111000;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Scans a 16-bit hex value across a 4-digit common-anode display with
// frame-synchronous updates, digit enables, decimal points and zero blanking.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] x,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  en_in,
    input  logic        lz_en,
    output logic [3:0]  AN,
    output logic [6:0]  a_to_g,
    output logic        dp,
    output logic        frame,
    output logic        pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    digit_rec_t       active_q, active_d;
    digit_rec_t       pend_rec_q, pend_rec_d;
    logic             pending_q, pending_d;
    logic             frame_q, frame_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic             boundary;
    logic [3:0]       nib;
    logic [6:0]       seg_raw;
    logic [3:0]       zero_from;
    logic [3:0]       blank;
    logic             shown;

    assign tick     = (cnt_q == CNT_W'(PRESCALE - 1));
    assign boundary = tick && (idx_q == 2'd3);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d = tick ? idx_q + 2'd1 : idx_q;
    end

    // A load on the boundary edge lands in the pending slot only, so active
    // takes the previous pending contents and pending stays asserted.
    always_comb begin
        active_d   = active_q;
        pend_rec_d = pend_rec_q;
        pending_d  = pending_q;
        frame_d    = 1'b0;
        if (boundary && pending_q) begin
            active_d  = pend_rec_q;
            pending_d = 1'b0;
            frame_d   = 1'b1;
        end
        if (load) begin
            pend_rec_d = {x, dp_in, en_in};
            pending_d  = 1'b1;
        end
    end

    assign nib = active_q.nibbles[{idx_q, 2'b00} +: 4];

    seg_decode u_seg_decode (
        .nib_i (nib),
        .seg_o (seg_raw)
    );

    // zero_from[i]: every nibble from i up to 3 is zero.
    always_comb begin
        zero_from[3] = (active_q.nibbles[15:12] == 4'h0);
        zero_from[2] = zero_from[3] && (active_q.nibbles[11:8] == 4'h0);
        zero_from[1] = zero_from[2] && (active_q.nibbles[7:4] == 4'h0);
        zero_from[0] = zero_from[1] && (active_q.nibbles[3:0] == 4'h0);
        blank        = {zero_from[3:1] & {3{lz_en}}, 1'b0};
        shown        = active_q.en[idx_q] && !blank[idx_q];
        an_d         = shown ? an_sel(idx_q) : AN_OFF;
        seg_d        = shown ? seg_raw : SEG_BLANK;
        dp_d         = shown ? ~active_q.dp[idx_q] : 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            active_q   <= '0;
            pend_rec_q <= '0;
            pending_q  <= 1'b0;
            frame_q    <= 1'b0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            pend_rec_q <= pend_rec_d;
            pending_q  <= pending_d;
            frame_q    <= frame_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign AN      = an_q;
    assign a_to_g  = seg_q;
    assign dp      = dp_q;
    assign frame   = frame_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomised bench for seg7_scan with a cycle-level behavioural model and
// a few hand-computed display expectations.
module tb_seg7_scan;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] x = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  en_in = 4'h0;
    logic [3:0]  AN;
    logic [6:0]  a_to_g;
    logic        dp;
    logic        frame;
    logic        pending;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [16];

    // Model state: edges since reset release, active and pending records.
    int          m_k;
    logic [15:0] m_ax, m_px;
    logic [3:0]  m_adp, m_aen, m_pdp, m_pen;
    logic        m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;

    seg7_scan #(
        .PRESCALE (P),
        .CNT_W    (2)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .x       (x),
        .load    (load),
        .dp_in   (dp_in),
        .en_in   (en_in),
        .lz_en   (lz_en),
        .AN      (AN),
        .a_to_g  (a_to_g),
        .dp      (dp),
        .frame   (frame),
        .pending (pending)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0;
        m_ax = 16'h0; m_px = 16'h0;
        m_adp = 4'h0; m_aen = 4'h0; m_pdp = 4'h0; m_pen = 4'h0;
        m_pend = 1'b0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
    endtask

    task automatic model_edge();
        int   cnt, idx;
        logic blank, shown, bnd;
        logic [3:0] nib;
        cnt   = m_k % P;
        idx   = (m_k / P) % 4;
        nib   = 4'((m_ax >> (4 * idx)) & 16'hF);
        blank = lz_en && (idx != 0) && ((m_ax >> (4 * idx)) == 16'h0);
        shown = m_aen[idx] && !blank;
        e_an  = shown ? ~(4'b0001 << idx) : 4'hF;
        e_seg = shown ? seg_tbl[nib] : 7'h7F;
        e_dp  = shown ? ~m_adp[idx] : 1'b1;
        bnd   = (cnt == P - 1) && (idx == 3);
        e_frame = bnd && m_pend;
        if (e_frame) begin
            m_ax = m_px; m_adp = m_pdp; m_aen = m_pen;
        end
        if (load) begin
            m_px = x; m_pdp = dp_in; m_pen = en_in;
        end
        m_pend = load || (m_pend && !bnd);
        m_k++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (clr) model_reset();
        else model_edge();
        chk("AN", AN, e_an);
        chk("a_to_g", a_to_g, e_seg);
        chk("dp", dp, e_dp);
        chk("frame", frame, e_frame);
        chk("pending", pending, m_pend);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic lit(input string name, input logic [3:0] an_e, input logic [6:0] seg_e,
                       input logic dp_e);
        chk({name, "_AN"}, AN, an_e);
        chk({name, "_seg"}, a_to_g, seg_e);
        chk({name, "_dp"}, dp, dp_e);
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpv);
        x = v; en_in = en; dp_in = dpv; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            seen = e_frame;
        end
        chk("frame_seen", 32'(seen), 1);
    endtask

    initial begin
        int n;
        seg_tbl[0]  = 7'b0000001; seg_tbl[1]  = 7'b1001111;
        seg_tbl[2]  = 7'b0010010; seg_tbl[3]  = 7'b0000110;
        seg_tbl[4]  = 7'b1001100; seg_tbl[5]  = 7'b0100100;
        seg_tbl[6]  = 7'b0100000; seg_tbl[7]  = 7'b0001111;
        seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0000100;
        seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b1100000;
        seg_tbl[12] = 7'b0110001; seg_tbl[13] = 7'b1000010;
        seg_tbl[14] = 7'b0110000; seg_tbl[15] = 7'b0111000;
        model_reset();

        // Reset held, then three idle frames.
        clr = 1'b1;
        steps(3);
        lit("reset", 4'hF, 7'h7F, 1'b1);
        clr = 1'b0;
        steps(3 * 4 * P);
        lit("idle", 4'hF, 7'h7F, 1'b1);
        chk("idle_pending", pending, 0);

        // 12AF, all digits on, decimal point on digit 2.
        load_val(16'h12AF, 4'b1111, 4'b0100);
        chk("pend_after_load", pending, 1);
        wait_frame();
        step();
        lit("d0_F", 4'b1110, 7'b0111000, 1'b1);
        steps(P);
        lit("d1_A", 4'b1101, 7'b0001000, 1'b1);
        steps(P);
        lit("d2_2", 4'b1011, 7'b0010010, 1'b0);
        steps(P);
        lit("d3_1", 4'b0111, 7'b1001111, 1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 700; c++) begin
            if (c % 32 == 0) lz_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                x = 16'($urandom);
                if ($urandom_range(0, 2) == 0) x = x & 16'h00FF;
                if ($urandom_range(0, 3) == 0) x = x & 16'h000F;
                en_in = 4'($urandom);
                dp_in = 4'($urandom);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;

        // Leading-zero blanking on 0050.
        lz_en = 1'b1;
        load_val(16'h0050, 4'b1111, 4'b0000);
        wait_frame();
        step();
        lit("lz_d0", 4'b1110, 7'b0000001, 1'b1);
        steps(P);
        lit("lz_d1", 4'b1101, 7'b0100100, 1'b1);
        steps(P);
        lit("lz_d2", 4'hF, 7'h7F, 1'b1);
        steps(P);
        lit("lz_d3", 4'hF, 7'h7F, 1'b1);

        // All-zero value keeps digit 0; disabled digit 0 goes dark.
        load_val(16'h0000, 4'b1111, 4'b0000);
        wait_frame();
        step();
        lit("zero_d0", 4'b1110, 7'b0000001, 1'b1);
        steps(P);
        lit("zero_d1", 4'hF, 7'h7F, 1'b1);
        load_val(16'h1234, 4'b1110, 4'b0000);
        wait_frame();
        step();
        lit("en_d0", 4'hF, 7'h7F, 1'b1);
        steps(P);
        lit("en_d1", 4'b1101, 7'b0000110, 1'b1);

        // Load coinciding with a boundary while another value is pending.
        lz_en = 1'b0;
        load_val(16'hAAAA, 4'b1111, 4'b0000);
        for (int i = 0; i < 20 && !((m_k % P == P - 1) && ((m_k / P) % 4 == 3)); i++) step();
        x = 16'h5555; load = 1'b1;
        step();
        load = 1'b0;
        chk("coin_frame", frame, 1);
        chk("coin_pending", pending, 1);
        step();
        lit("coin_old", 4'b1110, 7'b0001000, 1'b1);
        steps(3);
        load_val(16'h6666, 4'b1111, 4'b0000);
        chk("second_pending", pending, 1);
        wait_frame();
        chk("pending_cleared", pending, 0);
        step();
        lit("newest", 4'b1110, 7'b0100000, 1'b1);

        // Async reset mid-slot at idx 2.
        for (int i = 0; i < 20 && !((m_k % P == 1) && ((m_k / P) % 4 == 2)); i++) step();
        #2 clr = 1'b1;
        #1;
        lit("async_clr", 4'hF, 7'h7F, 1'b1);
        chk("async_frame", frame, 0);
        chk("async_pending", pending, 0);
        model_reset();
        steps(2);
        clr = 1'b0;
        load_val(16'h0008, 4'b0001, 4'b0001);
        n = 1;
        while (!e_frame && n < 40) begin
            step();
            n++;
        end
        chk("first_frame_edge", n, 16);
        step();
        lit("post_rst", 4'b1110, 7'b0000000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
